// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline slice: opcodes, memory-op encoding
// and the packed control bundle carried from decode into execute.
package id_ex_reg_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [4:0] MEM_OP_NONE      = 5'b00111;
   localparam int         MEM_OP_LOAD_BIT  = 3;
   localparam int         MEM_OP_STORE_BIT = 4;

   typedef struct packed {
      logic       imm_en;
      logic [6:0] op;
      logic [7:0] funct7;
      logic [2:0] funct3;
      logic [4:0] rd_addr;
      logic       rd_en;
      logic [4:0] mem_op;
      logic       jump_en;
      logic [4:0] rs1_addr;
      logic       rs1_en;
      logic [4:0] rs2_addr;
      logic       rs2_en;
   } id_ex_ctrl_t;

   // Bubble: a no-op that neither writes a register nor touches memory.
   localparam id_ex_ctrl_t CTRL_BUBBLE = '{
      imm_en:   1'b0,
      op:       7'd0,
      funct7:   8'd0,
      funct3:   3'd0,
      rd_addr:  5'd0,
      rd_en:    1'b0,
      mem_op:   MEM_OP_NONE,
      jump_en:  1'b0,
      rs1_addr: 5'd0,
      rs1_en:   1'b0,
      rs2_addr: 5'd0,
      rs2_en:   1'b0
   };

   function automatic logic is_load(input logic [4:0] mem_op);
      return mem_op[MEM_OP_LOAD_BIT];
   endfunction

endpackage

// File: rtl/id_ex_reg_hazard_unit.sv
// Combinational load-use compare between the instruction in EX and the one in ID.
// Kept generic so it can be reused for EX/MEM forwarding decisions.
module hazard_unit
   import id_ex_reg_pkg::*;
(
   input  logic       ex_valid,
   input  logic [4:0] ex_mem_op,
   input  logic       ex_rd_en,
   input  logic [4:0] ex_rd_addr,
   input  logic       id_valid,
   input  logic       rs1_en,
   input  logic [4:0] rs1_addr,
   input  logic       rs2_en,
   input  logic [4:0] rs2_addr,
   output logic       hazard
);

   logic ex_writes_reg;
   logic rs1_match;
   logic rs2_match;

   // x0 is never a real producer, so a load into x0 cannot stall anything.
   assign ex_writes_reg = ex_valid & is_load(ex_mem_op) & ex_rd_en & (ex_rd_addr != 5'd0);
   assign rs1_match     = rs1_en & (rs1_addr == ex_rd_addr);
   assign rs2_match     = rs2_en & (rs2_addr == ex_rd_addr);
   assign hazard        = ex_writes_reg & id_valid & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, downstream hold,
// branch flush and write-back bypass of the captured/held source operands.
module id_ex_reg
   import id_ex_reg_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CNT_W     = 16,
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid_i,
   input  logic [XLEN-1:0]  instr_addr_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic             imm_en_i,
   input  logic [6:0]       op_i,
   input  logic [7:0]       funct7_i,
   input  logic [2:0]       funct3_i,
   input  logic [4:0]       rd_addr_i,
   input  logic             rd_en_i,
   input  logic [4:0]       mem_op_i,
   input  logic             jump_en_i,
   input  logic [4:0]       rs1_addr_i,
   input  logic [4:0]       rs2_addr_i,
   input  logic             rs1_en_i,
   input  logic             rs2_en_i,
   input  logic [XLEN-1:0]  rs1_data_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   input  logic             wb_rd_en_i,
   input  logic [4:0]       wb_rd_addr_i,
   input  logic [XLEN-1:0]  wb_data_i,
   input  logic             ex_stall_i,
   input  logic             flush_i,
   output logic             id_stall_o,
   output logic             ex_valid_o,
   output logic [XLEN-1:0]  instr_addr_o,
   output logic [XLEN-1:0]  imm_o,
   output logic             imm_en_o,
   output logic [6:0]       op_o,
   output logic [7:0]       funct7_o,
   output logic [2:0]       funct3_o,
   output logic [4:0]       rd_addr_o,
   output logic             rd_en_o,
   output logic [4:0]       mem_op_o,
   output logic             jump_en_o,
   output logic [4:0]       rs1_addr_o,
   output logic             rs1_en_o,
   output logic [4:0]       rs2_addr_o,
   output logic             rs2_en_o,
   output logic [XLEN-1:0]  rs1_data_o,
   output logic [XLEN-1:0]  rs2_data_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   id_ex_ctrl_t      ctrl_p0;
   id_ex_ctrl_t      ctrl_p1;
   logic             vld_p1;
   logic [XLEN-1:0]  pc_p1;
   logic [XLEN-1:0]  imm_p1;
   logic [XLEN-1:0]  rs1_data_p1;
   logic [XLEN-1:0]  rs2_data_p1;
   logic [CNT_W-1:0] cnt_p1;

   logic hazard;
   logic wb_live;
   logic cap_rs1_hit;
   logic cap_rs2_hit;
   logic hold_rs1_hit;
   logic hold_rs2_hit;

   always_comb begin
      ctrl_p0          = CTRL_BUBBLE;
      ctrl_p0.imm_en   = imm_en_i;
      ctrl_p0.op       = op_i;
      ctrl_p0.funct7   = funct7_i;
      ctrl_p0.funct3   = funct3_i;
      ctrl_p0.rd_addr  = rd_addr_i;
      ctrl_p0.rd_en    = rd_en_i;
      ctrl_p0.mem_op   = mem_op_i;
      ctrl_p0.jump_en  = jump_en_i;
      ctrl_p0.rs1_addr = rs1_addr_i;
      ctrl_p0.rs1_en   = rs1_en_i;
      ctrl_p0.rs2_addr = rs2_addr_i;
      ctrl_p0.rs2_en   = rs2_en_i;
   end

   hazard_unit u_hazard (
      .ex_valid   (vld_p1),
      .ex_mem_op  (ctrl_p1.mem_op),
      .ex_rd_en   (ctrl_p1.rd_en),
      .ex_rd_addr (ctrl_p1.rd_addr),
      .id_valid   (id_valid_i),
      .rs1_en     (rs1_en_i),
      .rs1_addr   (rs1_addr_i),
      .rs2_en     (rs2_en_i),
      .rs2_addr   (rs2_addr_i),
      .hazard     (hazard)
   );

   // A flush redirects fetch anyway, so it must never hold IF/ID.
   assign id_stall_o = ~flush_i & (ex_stall_i | hazard);

   // Write-back matches: on capture against the incoming rs addresses, while
   // held against the live EX operands so a stalled consumer sees fresh data.
   assign wb_live      = (WB_BYPASS != 1'b0) & wb_rd_en_i & (wb_rd_addr_i != 5'd0);
   assign cap_rs1_hit  = wb_live & (wb_rd_addr_i == rs1_addr_i);
   assign cap_rs2_hit  = wb_live & (wb_rd_addr_i == rs2_addr_i);
   assign hold_rs1_hit = wb_live & vld_p1 & ctrl_p1.rs1_en & (wb_rd_addr_i == ctrl_p1.rs1_addr);
   assign hold_rs2_hit = wb_live & vld_p1 & ctrl_p1.rs2_en & (wb_rd_addr_i == ctrl_p1.rs2_addr);

   // ---- ID -> EX stage boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         ctrl_p1     <= CTRL_BUBBLE;
         pc_p1       <= '0;
         imm_p1      <= '0;
         rs1_data_p1 <= '0;
         rs2_data_p1 <= '0;
         cnt_p1      <= '0;
      end else if (flush_i) begin
         vld_p1      <= 1'b0;
         ctrl_p1     <= CTRL_BUBBLE;
         pc_p1       <= '0;
         imm_p1      <= '0;
         rs1_data_p1 <= '0;
         rs2_data_p1 <= '0;
      end else if (ex_stall_i) begin
         if (hold_rs1_hit) rs1_data_p1 <= wb_data_i;
         if (hold_rs2_hit) rs2_data_p1 <= wb_data_i;
      end else if (hazard) begin
         vld_p1      <= 1'b0;
         ctrl_p1     <= CTRL_BUBBLE;
         pc_p1       <= '0;
         imm_p1      <= '0;
         rs1_data_p1 <= '0;
         rs2_data_p1 <= '0;
         cnt_p1      <= sat_inc(cnt_p1);
      end else begin
         vld_p1      <= id_valid_i;
         ctrl_p1     <= id_valid_i ? ctrl_p0 : CTRL_BUBBLE;
         pc_p1       <= instr_addr_i;
         imm_p1      <= imm_i;
         rs1_data_p1 <= cap_rs1_hit ? wb_data_i : rs1_data_i;
         rs2_data_p1 <= cap_rs2_hit ? wb_data_i : rs2_data_i;
      end
   end

   assign ex_valid_o   = vld_p1;
   assign instr_addr_o = pc_p1;
   assign imm_o        = imm_p1;
   assign imm_en_o     = ctrl_p1.imm_en;
   assign op_o         = ctrl_p1.op;
   assign funct7_o     = ctrl_p1.funct7;
   assign funct3_o     = ctrl_p1.funct3;
   assign rd_addr_o    = ctrl_p1.rd_addr;
   assign rd_en_o      = ctrl_p1.rd_en;
   assign mem_op_o     = ctrl_p1.mem_op;
   assign jump_en_o    = ctrl_p1.jump_en;
   assign rs1_addr_o   = ctrl_p1.rs1_addr;
   assign rs1_en_o     = ctrl_p1.rs1_en;
   assign rs2_addr_o   = ctrl_p1.rs2_addr;
   assign rs2_en_o     = ctrl_p1.rs2_en;
   assign rs1_data_o   = rs1_data_p1;
   assign rs2_data_o   = rs2_data_p1;
   assign bubble_cnt_o = cnt_p1;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed table-driven bench for id_ex_reg plus hand sequences for hold,
// async reset and bubble-counter saturation.
module tb_id_ex_reg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   typedef struct {
      logic        id_valid;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        imm_en;
      logic [6:0]  op;
      logic [7:0]  f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        rd_en;
      logic [4:0]  mem_op;
      logic        jump;
      logic [4:0]  rs1;
      logic        rs1_en;
      logic [31:0] d1;
      logic [4:0]  rs2;
      logic        rs2_en;
      logic [31:0] d2;
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        ex_stall;
      logic        flush;
      logic        e_stall;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [4:0]  e_rd;
      logic [4:0]  e_mem;
      logic [31:0] e_d1;
      logic [31:0] e_d2;
      logic [3:0]  e_cnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid_i;
   logic [XLEN-1:0]  instr_addr_i, imm_i;
   logic             imm_en_i;
   logic [6:0]       op_i;
   logic [7:0]       funct7_i;
   logic [2:0]       funct3_i;
   logic [4:0]       rd_addr_i;
   logic             rd_en_i;
   logic [4:0]       mem_op_i;
   logic             jump_en_i;
   logic [4:0]       rs1_addr_i, rs2_addr_i;
   logic             rs1_en_i, rs2_en_i;
   logic [XLEN-1:0]  rs1_data_i, rs2_data_i;
   logic             wb_rd_en_i;
   logic [4:0]       wb_rd_addr_i;
   logic [XLEN-1:0]  wb_data_i;
   logic             ex_stall_i, flush_i;
   logic             id_stall_o, ex_valid_o;
   logic [XLEN-1:0]  instr_addr_o, imm_o;
   logic             imm_en_o;
   logic [6:0]       op_o;
   logic [7:0]       funct7_o;
   logic [2:0]       funct3_o;
   logic [4:0]       rd_addr_o;
   logic             rd_en_o;
   logic [4:0]       mem_op_o;
   logic             jump_en_o;
   logic [4:0]       rs1_addr_o, rs2_addr_o;
   logic             rs1_en_o, rs2_en_o;
   logic [XLEN-1:0]  rs1_data_o, rs2_data_o;
   logic [CNT_W-1:0] bubble_cnt_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W), .WB_BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
      .instr_addr_i(instr_addr_i), .imm_i(imm_i), .imm_en_i(imm_en_i),
      .op_i(op_i), .funct7_i(funct7_i), .funct3_i(funct3_i),
      .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i), .mem_op_i(mem_op_i),
      .jump_en_i(jump_en_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_en_i(rs1_en_i), .rs2_en_i(rs2_en_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .wb_rd_en_i(wb_rd_en_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
      .ex_stall_i(ex_stall_i), .flush_i(flush_i),
      .id_stall_o(id_stall_o), .ex_valid_o(ex_valid_o),
      .instr_addr_o(instr_addr_o), .imm_o(imm_o), .imm_en_o(imm_en_o),
      .op_o(op_o), .funct7_o(funct7_o), .funct3_o(funct3_o),
      .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o), .mem_op_o(mem_op_o),
      .jump_en_o(jump_en_o), .rs1_addr_o(rs1_addr_o), .rs1_en_o(rs1_en_o),
      .rs2_addr_o(rs2_addr_o), .rs2_en_o(rs2_en_o),
      .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
      .bubble_cnt_o(bubble_cnt_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk_in(input logic [31:0] pc, input logic [6:0] op,
                                  input logic [4:0] rd, input logic rd_en, input logic [4:0] mem_op,
                                  input logic [4:0] rs1, input logic rs1_en, input logic [31:0] d1,
                                  input logic [4:0] rs2, input logic rs2_en, input logic [31:0] d2);
      vec_t v;
      v.id_valid = 1'b1; v.pc = pc; v.imm = {20'h0, pc[11:0]}; v.imm_en = 1'b0;
      v.op = op; v.f7 = 8'h0; v.f3 = 3'h0; v.rd = rd; v.rd_en = rd_en;
      v.mem_op = mem_op; v.jump = 1'b0;
      v.rs1 = rs1; v.rs1_en = rs1_en; v.d1 = d1;
      v.rs2 = rs2; v.rs2_en = rs2_en; v.d2 = d2;
      v.wb_en = 1'b0; v.wb_addr = 5'd0; v.wb_data = 32'h0;
      v.ex_stall = 1'b0; v.flush = 1'b0;
      v.e_stall = 1'b0; v.e_vld = 1'b0; v.e_pc = 32'h0; v.e_rd = 5'd0;
      v.e_mem = 5'b00111; v.e_d1 = 32'h0; v.e_d2 = 32'h0; v.e_cnt = 4'h0;
      return v;
   endfunction

   function automatic vec_t with_exp(input vec_t v, input logic stall, input logic vld,
                                     input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] mem,
                                     input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] cnt);
      vec_t r = v;
      r.e_stall = stall; r.e_vld = vld; r.e_pc = pc; r.e_rd = rd;
      r.e_mem = mem; r.e_d1 = d1; r.e_d2 = d2; r.e_cnt = cnt;
      return r;
   endfunction

   task automatic drive(input vec_t v);
      id_valid_i = v.id_valid; instr_addr_i = v.pc; imm_i = v.imm; imm_en_i = v.imm_en;
      op_i = v.op; funct7_i = v.f7; funct3_i = v.f3; rd_addr_i = v.rd; rd_en_i = v.rd_en;
      mem_op_i = v.mem_op; jump_en_i = v.jump;
      rs1_addr_i = v.rs1; rs1_en_i = v.rs1_en; rs1_data_i = v.d1;
      rs2_addr_i = v.rs2; rs2_en_i = v.rs2_en; rs2_data_i = v.d2;
      wb_rd_en_i = v.wb_en; wb_rd_addr_i = v.wb_addr; wb_data_i = v.wb_data;
      ex_stall_i = v.ex_stall; flush_i = v.flush;
   endtask

   // Drive one vector, check the combinational stall before the edge, then the registered outputs.
   task automatic step(input vec_t v, input string tag);
      drive(v);
      #3;
      chk({tag, ".id_stall"}, {31'h0, id_stall_o}, {31'h0, v.e_stall});
      @(posedge clk);
      #1;
      chk({tag, ".ex_valid"}, {31'h0, ex_valid_o}, {31'h0, v.e_vld});
      chk({tag, ".instr_addr"}, instr_addr_o, v.e_pc);
      chk({tag, ".rd_addr"}, {27'h0, rd_addr_o}, {27'h0, v.e_rd});
      chk({tag, ".mem_op"}, {27'h0, mem_op_o}, {27'h0, v.e_mem});
      chk({tag, ".rs1_data"}, rs1_data_o, v.e_d1);
      chk({tag, ".rs2_data"}, rs2_data_o, v.e_d2);
      chk({tag, ".bubble_cnt"}, {28'h0, bubble_cnt_o}, {28'h0, v.e_cnt});
   endtask

   task automatic chk_fields(input vec_t v, input string tag);
      chk({tag, ".imm"}, imm_o, v.imm);
      chk({tag, ".imm_en"}, {31'h0, imm_en_o}, {31'h0, v.imm_en});
      chk({tag, ".op"}, {25'h0, op_o}, {25'h0, v.op});
      chk({tag, ".funct7"}, {24'h0, funct7_o}, {24'h0, v.f7});
      chk({tag, ".funct3"}, {29'h0, funct3_o}, {29'h0, v.f3});
      chk({tag, ".rd_en"}, {31'h0, rd_en_o}, {31'h0, v.rd_en});
      chk({tag, ".jump_en"}, {31'h0, jump_en_o}, {31'h0, v.jump});
      chk({tag, ".rs1_addr"}, {27'h0, rs1_addr_o}, {27'h0, v.rs1});
      chk({tag, ".rs1_en"}, {31'h0, rs1_en_o}, {31'h0, v.rs1_en});
      chk({tag, ".rs2_addr"}, {27'h0, rs2_addr_o}, {27'h0, v.rs2});
      chk({tag, ".rs2_en"}, {31'h0, rs2_en_o}, {31'h0, v.rs2_en});
   endtask

   localparam logic [6:0] ALU  = 7'b0110011;
   localparam logic [6:0] LD   = 7'b0000011;
   localparam logic [6:0] ALUI = 7'b0010011;
   localparam logic [4:0] NONE = 5'b00111;
   localparam logic [4:0] LW   = 5'b01010;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      vec_t tbl [15];
      vec_t v, held, other;

      tbl[0]  = with_exp(mk_in(32'h100, ALU, 5'd3, 1, NONE, 5'd1, 1, 32'h11, 5'd2, 1, 32'h22),
                         0, 1, 32'h100, 5'd3, NONE, 32'h11, 32'h22, 4'd0);
      tbl[1]  = with_exp(mk_in(32'h104, LD, 5'd5, 1, LW, 5'd1, 1, 32'h1000, 5'd0, 0, 32'h0),
                         0, 1, 32'h104, 5'd5, LW, 32'h1000, 32'h0, 4'd0);
      tbl[2]  = with_exp(mk_in(32'h108, ALU, 5'd7, 1, NONE, 5'd5, 1, 32'h55, 5'd6, 1, 32'h66),
                         1, 0, 32'h0, 5'd0, NONE, 32'h0, 32'h0, 4'd1);
      tbl[3]  = with_exp(mk_in(32'h108, ALU, 5'd7, 1, NONE, 5'd5, 1, 32'h55, 5'd6, 1, 32'h66),
                         0, 1, 32'h108, 5'd7, NONE, 32'hAAAA5555, 32'h66, 4'd1);
      tbl[3].wb_en = 1; tbl[3].wb_addr = 5'd5; tbl[3].wb_data = 32'hAAAA5555;
      tbl[4]  = with_exp(mk_in(32'h10C, LD, 5'd0, 1, LW, 5'd2, 1, 32'h2, 5'd0, 0, 32'h0),
                         0, 1, 32'h10C, 5'd0, LW, 32'h2, 32'h0, 4'd1);
      tbl[5]  = with_exp(mk_in(32'h110, ALU, 5'd8, 1, NONE, 5'd0, 1, 32'h0, 5'd0, 1, 32'h0),
                         0, 1, 32'h110, 5'd8, NONE, 32'h0, 32'h0, 4'd1);
      tbl[5].wb_en = 1; tbl[5].wb_addr = 5'd0; tbl[5].wb_data = 32'hFFFF;
      tbl[6]  = with_exp(mk_in(32'h114, LD, 5'd5, 1, LW, 5'd1, 1, 32'h40, 5'd0, 0, 32'h0),
                         0, 1, 32'h114, 5'd5, LW, 32'h40, 32'h0, 4'd1);
      tbl[7]  = with_exp(mk_in(32'h118, ALUI, 5'd9, 1, NONE, 5'd1, 1, 32'h1, 5'd5, 0, 32'h77),
                         0, 1, 32'h118, 5'd9, NONE, 32'h1, 32'h77, 4'd1);
      tbl[8]  = with_exp(mk_in(32'h0, LD, 5'd10, 1, LW, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0),
                         0, 0, 32'h0, 5'd0, NONE, 32'h0, 32'h0, 4'd1);
      tbl[8].id_valid = 0; tbl[8].imm = 32'h0;
      tbl[9]  = with_exp(mk_in(32'h11C, LD, 5'd5, 1, LW, 5'd1, 1, 32'h8, 5'd0, 0, 32'h0),
                         0, 1, 32'h11C, 5'd5, LW, 32'h8, 32'h0, 4'd1);
      tbl[10] = with_exp(mk_in(32'h120, ALU, 5'd4, 1, NONE, 5'd5, 1, 32'h5, 5'd0, 0, 32'h0),
                         0, 0, 32'h0, 5'd0, NONE, 32'h0, 32'h0, 4'd1);
      tbl[10].ex_stall = 1; tbl[10].flush = 1;
      tbl[11] = with_exp(mk_in(32'h120, LD, 5'd6, 1, LW, 5'd1, 1, 32'h9, 5'd0, 0, 32'h0),
                         0, 1, 32'h120, 5'd6, LW, 32'h9, 32'h0, 4'd1);
      tbl[12] = with_exp(mk_in(32'h124, ALU, 5'd11, 1, NONE, 5'd3, 1, 32'h3, 5'd6, 1, 32'h66),
                         1, 1, 32'h120, 5'd6, LW, 32'h9, 32'h0, 4'd1);
      tbl[12].ex_stall = 1;
      tbl[13] = with_exp(mk_in(32'h124, ALU, 5'd11, 1, NONE, 5'd3, 1, 32'h3, 5'd6, 1, 32'h66),
                         1, 0, 32'h0, 5'd0, NONE, 32'h0, 32'h0, 4'd2);
      tbl[14] = with_exp(mk_in(32'h124, ALU, 5'd11, 1, NONE, 5'd3, 1, 32'h3, 5'd6, 1, 32'h66),
                         0, 1, 32'h124, 5'd11, NONE, 32'h3, 32'h66, 4'd2);

      rst_n = 1'b0;
      drive(mk_in(32'h0, 7'h0, 5'd0, 0, NONE, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0));
      repeat (2) @(posedge clk);
      #1;
      chk("reset.ex_valid", {31'h0, ex_valid_o}, 32'h0);
      chk("reset.mem_op", {27'h0, mem_op_o}, {27'h0, NONE});
      chk("reset.bubble_cnt", {28'h0, bubble_cnt_o}, 32'h0);
      chk("reset.instr_addr", instr_addr_o, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("v%0d", i));

      // Hold with WB refresh of the held rs1 operand.
      held = with_exp(mk_in(32'h200, ALU, 5'd12, 1, NONE, 5'd7, 1, 32'h70, 5'd8, 0, 32'h1234),
                      0, 1, 32'h200, 5'd12, NONE, 32'h70, 32'h1234, 4'd2);
      held.imm = 32'hFFFFFFF0; held.imm_en = 1; held.f7 = 8'h20; held.f3 = 3'b101; held.jump = 1;
      step(held, "hold.cap");
      chk_fields(held, "hold.cap");
      for (int c = 1; c <= 3; c++) begin
         other = mk_in(32'h204, ALUI, 5'd13, 1, NONE, 5'd1, 1, 32'h1, 5'd2, 1, 32'h2);
         other.ex_stall = 1;
         if (c == 2) begin other.wb_en = 1; other.wb_addr = 5'd7; other.wb_data = 32'hDEADBEEF; end
         if (c == 3) begin other.wb_en = 1; other.wb_addr = 5'd8; other.wb_data = 32'h5555; end
         other = with_exp(other, 1, 1, 32'h200, 5'd12, NONE,
                          (c >= 2) ? 32'hDEADBEEF : 32'h70, 32'h1234, 4'd2);
         step(other, $sformatf("hold.c%0d", c));
         chk_fields(held, $sformatf("hold.c%0d", c));
      end

      // Asynchronous reset mid-capture clears without a clock edge.
      drive(mk_in(32'h0, 7'h0, 5'd0, 0, NONE, 5'd0, 0, 32'h0, 5'd0, 0, 32'h0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset.ex_valid", {31'h0, ex_valid_o}, 32'h0);
      chk("areset.mem_op", {27'h0, mem_op_o}, {27'h0, NONE});
      chk("areset.bubble_cnt", {28'h0, bubble_cnt_o}, 32'h0);
      chk("areset.rs1_data", rs1_data_o, 32'h0);
      chk("areset.rd_addr", {27'h0, rd_addr_o}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v = with_exp(mk_in(32'h300, ALU, 5'd1, 1, NONE, 5'd2, 1, 32'h1, 5'd3, 1, 32'h2),
                   0, 1, 32'h300, 5'd1, NONE, 32'h1, 32'h2, 4'd0);
      step(v, "release");

      // Saturating bubble counter.
      for (int i = 0; i < 17; i++) begin
         v = with_exp(mk_in(32'h400, LD, 5'd5, 1, LW, 5'd1, 1, 32'h4, 5'd0, 0, 32'h0),
                      0, 1, 32'h400, 5'd5, LW, 32'h4, 32'h0, (i > 15) ? 4'hF : 4'(i));
         step(v, $sformatf("sat%0d.lw", i));
         v = with_exp(mk_in(32'h404, ALU, 5'd6, 1, NONE, 5'd5, 1, 32'h5, 5'd0, 0, 32'h0),
                      1, 0, 32'h0, 5'd0, NONE, 32'h0, 32'h0, (i >= 14) ? 4'hF : 4'(i + 1));
         step(v, $sformatf("sat%0d.use", i));
      end
      chk("sat.final", {28'h0, bubble_cnt_o}, 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register; captures the instruction decoder's fields plus register-file read data and PC each cycle and presents them to the EX stage one cycle later.
- Detects load-use hazards against the instruction currently in EX. On a hazard it inserts a bubble and stalls IF/ID and the PC.
- Also handles downstream stall (hold), branch flush (kill), and write-back bypass of source operands, including while held.

Parameters:
- XLEN, 32, datapath/immediate/PC width
- CNT_W, 16, width of saturating bubble counter
- WB_BYPASS, 1, 1 = bypass same-cycle WB write into captured/held rs data

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID stage holds a valid instruction
- instr_addr_i  in  XLEN  PC of ID instruction
- imm_i  in  XLEN  decoded immediate
- imm_en_i  in  1  immediate used
- op_i  in  7  opcode
- funct7_i  in  8  {1'b0, instr[31:25]}
- funct3_i  in  3  funct3
- rd_addr_i  in  5  destination register
- rd_en_i  in  1  rd write enable
- mem_op_i  in  5  [2:0] size/sign, [3] load, [4] store
- jump_en_i  in  1  JAL/JALR/branch
- rs1_addr_i, rs2_addr_i  in  5 each  source registers
- rs1_en_i, rs2_en_i  in  1 each  source read enables
- rs1_data_i, rs2_data_i  in  XLEN each  register-file read data
- wb_rd_en_i  in  1  write-back write enable
- wb_rd_addr_i  in  5  write-back register
- wb_data_i  in  XLEN  write-back data
- ex_stall_i  in  1  EX/MEM cannot accept; hold contents
- flush_i  in  1  branch/jump redirect; kill ID/EX contents
- id_stall_o  out  1  hold PC and IF/ID (combinational)
- ex_valid_o  out  1  EX instruction valid
- instr_addr_o, imm_o, imm_en_o, op_o, funct7_o, funct3_o, rd_addr_o, rd_en_o, mem_op_o, jump_en_o, rs1_addr_o, rs1_en_o, rs2_addr_o, rs2_en_o, rs1_data_o, rs2_data_o  out  same widths as inputs  registered copies
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, rst_n=0): every output register 0 except mem_op_o=5'b00111. ex_valid_o=0. bubble_cnt_o=0. On release, the next edge performs a normal capture.
- Bubble/flush value: same as the reset value, but bubble_cnt_o is not cleared.
- hazard = ex_valid_o & mem_op_o[3] & rd_en_o & (rd_addr_o!=0) & id_valid_i & ((rs1_en_i & rs1_addr_i==rd_addr_o) | (rs2_en_i & rs2_addr_i==rd_addr_o)).
- id_stall_o = ~flush_i & (ex_stall_i | hazard).
- Per-edge priority, highest first:
  1. flush_i: load bubble value.
  2. ex_stall_i: hold all fields; apply WB refresh.
  3. hazard: load bubble value; bubble_cnt_o += 1, saturating at all-ones.
  4. Otherwise: capture inputs; ex_valid_o <= id_valid_i. If id_valid_i=0, control fields take the bubble value.
- Latency: 1 cycle, ID to EX. No combinational path from data inputs to data outputs.
- Capture bypass (WB_BYPASS=1): if wb_rd_en_i & wb_rd_addr_i!=0 & wb_rd_addr_i==rs1_addr_i, then rs1_data_o <= wb_data_i. Same rule for rs2.
- WB refresh while held: if wb_rd_en_i & wb_rd_addr_i!=0 & ex_valid_o & rs1_en_o & wb_rd_addr_i==rs1_addr_o, then rs1_data_o <= wb_data_i. Same rule for rs2. Other fields stay unchanged.
- A hazard while ex_stall_i=1 inserts no bubble and does not count. The bubble is inserted on the first unstalled edge where the hazard still holds.
- A hazard with x0 as the destination never fires.
- flush_i with hazard or ex_stall_i present: flush wins and id_stall_o=0.

Decomposition:
- Shared package holds: opcode constants (OP_LOAD=7'b0000011, OP_STORE=7'b0100011, etc.), MEM_OP_NONE=5'b00111, MEM_OP_LOAD_BIT=3, MEM_OP_STORE_BIT=4, and a packed struct for the ID/EX control bundle.
- Sub-module hazard_unit: combinational load-use compare producing hazard. It is instantiated here and is reusable later for EX/MEM forwarding.

Test Plan:
- Reset: assert rst_n=0 mid-capture (ex_valid_o=1) -> outputs clear immediately, without waiting for a clock edge; mem_op_o=5'b00111, bubble_cnt_o=0.
- Load-use: EX holds LW x5 (mem_op_o=5'b01010, rd_addr_o=5); ID presents ADD with rs1=x5 -> id_stall_o=1 that cycle; next edge ex_valid_o=0 and bubble_cnt_o=1; following edge the ADD is captured with ex_valid_o=1.
- x0 load and no-match: LW x0 followed by rs1=x0 -> no stall. LW x5 followed by an instruction with rs2_en_i=0 and rs2=x5 -> no stall.
- Stall hold with WB refresh: ex_stall_i=1 for 3 cycles while EX holds ADD rs1=x7; WB writes x7=32'hDEADBEEF in cycle 2 -> rs1_data_o=32'hDEADBEEF and all other fields unchanged; id_stall_o=1 throughout.
- Flush priority: flush_i=1 together with ex_stall_i=1 and a hazard -> next edge ex_valid_o=0, mem_op_o=5'b00111, id_stall_o=0, bubble_cnt_o unchanged.
- Counter saturation (CNT_W=4): run 17 load-use bubbles -> bubble_cnt_o reaches 4'hF and stays there.
